// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the handshaked sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_datapath.sv
// Single-cycle logic/arithmetic core; SUB and SLT share the A + ~B + 1 adder.
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             overflow
);

   logic             use_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf_raw;

   always_comb begin
      use_sub = (op == OP_SUB) || (op == OP_SLT);
      b_eff   = use_sub ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
      // Signed overflow: operands agree in sign but the sum does not.
      ovf_raw = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

      y        = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_ADD, OP_SUB: begin
            y        = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = ovf_raw;
         end
         OP_SLT: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked N-bit ALU: one-cycle logic/arith ops, bit-serial logical shifts,
// registered result and flags held until the consumer takes them.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Op,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Zero,
   output logic             Negative
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh_reg, sh_next, res, dp_y;
   logic [SHW-1:0]   cnt, shamt;
   logic             sh_right, res_c, res_v, dp_c, dp_v;
   logic             accept, is_shift, long_shift;

   alu_datapath #(.WIDTH(WIDTH)) u_dp (
      .a        (A),
      .b        (B),
      .op       (Op),
      .y        (dp_y),
      .carry    (dp_c),
      .overflow (dp_v)
   );

   assign shamt      = B[SHW-1:0];
   assign is_shift   = (Op == OP_SLL) || (Op == OP_SRL);
   assign long_shift = is_shift && (shamt != '0);
   assign accept     = InValid && InReady;
   assign sh_next    = sh_right ? (sh_reg >> 1) : (sh_reg << 1);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = long_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (cnt == SHW'(1)) state_nxt = S_DONE;
         S_DONE: begin
            // A consumed result may be replaced by a new op in the same cycle.
            if (OutReady) state_nxt = accept ? (long_shift ? S_SHIFT : S_DONE) : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      InReady  = 1'b0;
      OutValid = 1'b0;
      case (state)
         S_IDLE:  InReady = 1'b1;
         S_DONE: begin
            OutValid = 1'b1;
            InReady  = OutReady;
         end
         default: begin
            InReady  = 1'b0;
            OutValid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         res      <= '0;
         res_c    <= 1'b0;
         res_v    <= 1'b0;
         sh_reg   <= '0;
         cnt      <= '0;
         sh_right <= 1'b0;
      end else if (accept) begin
         if (!is_shift) begin
            res   <= dp_y;
            res_c <= dp_c;
            res_v <= dp_v;
         end else if (shamt == '0) begin
            res   <= A;
            res_c <= 1'b0;
            res_v <= 1'b0;
         end else begin
            sh_reg   <= A;
            cnt      <= shamt;
            sh_right <= (Op == OP_SRL);
         end
      end else if (state == S_SHIFT) begin
         // Amounts >= WIDTH simply run out of bits and leave zero.
         sh_reg <= sh_next;
         cnt    <= cnt - SHW'(1);
         if (cnt == SHW'(1)) begin
            res   <= sh_next;
            res_c <= 1'b0;
            res_v <= 1'b0;
         end
      end
   end

   assign Result   = res;
   assign CarryOut = res_c;
   assign Overflow = res_v;
   assign Zero     = (res == '0);
   assign Negative = res[WIDTH-1];

endmodule
